// File: rtl/state_machine3_29_driver_if.sv
// Bus between the stimulus driver and its environment: run control, patterns,
// target-machine pins and captured response. Self-check pins need DRIVER_SELF_CHECK_EN.
interface state_machine3_29_driver_if #(
   parameter int N = 8
);
   localparam int IW = $clog2(N);

   logic         start;
   logic [N-1:0] a_pat;
   logic [N-1:0] b_pat;
   logic         q_in;
   logic         dut_rst;
   logic         a;
   logic         b;
   logic         busy;
   logic         done;
   logic [N-1:0] q_word;
`ifdef DRIVER_SELF_CHECK_EN
   logic          mismatch;
   logic [IW-1:0] err_idx;
`endif

   modport master (
      input  start, a_pat, b_pat, q_in,
`ifdef DRIVER_SELF_CHECK_EN
      output mismatch, err_idx,
`endif
      output dut_rst, a, b, busy, done, q_word
   );

   modport slave (
      output start, a_pat, b_pat, q_in,
`ifdef DRIVER_SELF_CHECK_EN
      input  mismatch, err_idx,
`endif
      input  dut_rst, a, b, busy, done, q_word
   );
endinterface

// File: rtl/state_machine3_29_driver.sv
// Stimulus driver for the two-input Mealy target: PRIME resets it, RUN streams N (a,b)
// pairs LSB first and captures q. Optional DRIVER_SELF_CHECK_EN adds an internal reference model.
module state_machine3_29_driver #(
   parameter int N = 8
) (
   input logic                     clk,
   input logic                     reset,
   state_machine3_29_driver_if.master bus
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, FIN} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, b_q, q_word_q;
   logic [IW-1:0] idx_q;
   logic          accept;
   logic          dut_rst_o, a_o, b_o, busy_o, done_o;

   assign accept = (state_q == IDLE) && bus.start;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = PRIME;
         PRIME:   state_d = RUN;
         RUN:     if (idx_q == LAST) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend on state and latched patterns only, never on start.
   always_comb begin
      dut_rst_o = 1'b0;
      a_o       = 1'b0;
      b_o       = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         PRIME: begin
            dut_rst_o = 1'b1;
            busy_o    = 1'b1;
         end
         RUN: begin
            a_o    = a_q[idx_q];
            b_o    = b_q[idx_q];
            busy_o = 1'b1;
         end
         FIN:     done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         q_word_q <= '0;
         idx_q    <= '0;
      end else if (accept) begin
         a_q      <= bus.a_pat;
         b_q      <= bus.b_pat;
         q_word_q <= '0;
         idx_q    <= '0;
      end else if (state_q == RUN) begin
         q_word_q[idx_q] <= bus.q_in;
         if (idx_q != LAST) idx_q <= idx_q + 1'b1;
      end
   end

   assign bus.dut_rst = dut_rst_o;
   assign bus.a       = a_o;
   assign bus.b       = b_o;
   assign bus.busy    = busy_o;
   assign bus.done    = done_o;
   assign bus.q_word  = q_word_q;

`ifdef DRIVER_SELF_CHECK_EN
   logic          s_q, mismatch_q, q_exp;
   logic [IW-1:0] err_idx_q;

   assign q_exp = (~b_o & a_o & s_q) | (b_o & (a_o | s_q));

   // Only the first failing index is kept; mismatch stays set until the next run.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q        <= 1'b0;
         mismatch_q <= 1'b0;
         err_idx_q  <= '0;
      end else if (accept) begin
         mismatch_q <= 1'b0;
         err_idx_q  <= '0;
      end else if (state_q == PRIME) begin
         s_q <= 1'b0;
      end else if (state_q == RUN) begin
         s_q <= a_o;
         if ((bus.q_in != q_exp) && !mismatch_q) begin
            mismatch_q <= 1'b1;
            err_idx_q  <= idx_q;
         end
      end
   end

   assign bus.mismatch = mismatch_q;
   assign bus.err_idx  = err_idx_q;
`endif
endmodule

// File: tb/tb_state_machine3_29_driver.sv
// Scoreboard bench: stimulus pushes expected run results, a negedge monitor checks each done.
module tb_state_machine3_29_driver;
   localparam int N = 8;

   logic clk, reset, force_q, s_t;
   int   cyc, total, bad;

   state_machine3_29_driver_if #(.N(N)) bus();

   state_machine3_29_driver #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Target Mealy machine: s holds previous a, cleared by dut_rst.
   always @(posedge clk) begin
      if (reset || bus.dut_rst) s_t <= 1'b0;
      else                      s_t <= bus.a;
   end
   assign bus.q_in = force_q ? 1'b0 :
                     ((~bus.b & bus.a & s_t) | (bus.b & (bus.a | s_t)));

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           prime_cyc;
      int           done_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   int           busy_n, prime_n, prime_at, run_k;
   logic [N-1:0] a_tr, b_tr;

   always @(negedge clk) begin
      if (bus.done) begin
         chk("fin_outputs", {bus.busy, bus.a, bus.b, bus.dut_rst}, 4'b0000);
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("q_word", bus.q_word, mon_e.q);
            chk("a_trace", a_tr, mon_e.a);
            chk("b_trace", b_tr, mon_e.b);
            chk("busy_cycles", busy_n, N + 1);
            chk("prime_cycles", prime_n, 1);
            chk("prime_at", prime_at, mon_e.prime_cyc);
            chk("done_at", cyc, mon_e.done_cyc);
         end
         busy_n = 0; prime_n = 0; prime_at = -1; run_k = 0; a_tr = '0; b_tr = '0;
      end else if (!bus.busy) begin
         busy_n = 0; prime_n = 0; prime_at = -1; run_k = 0; a_tr = '0; b_tr = '0;
      end else begin
         busy_n++;
         if (bus.dut_rst) begin
            prime_n++;
            prime_at = cyc;
            chk("prime_ab", {bus.a, bus.b}, 2'b00);
         end else begin
            if (run_k < N) begin
               a_tr[run_k] = bus.a;
               b_tr[run_k] = bus.b;
            end
            run_k++;
         end
      end
   end

   task automatic kick(input logic [N-1:0] ap, input logic [N-1:0] bp, input logic [N-1:0] qexp);
      int t0;
      @(negedge clk);
      bus.a_pat = ap; bus.b_pat = bp; bus.start = 1'b1;
      t0 = cyc;
      sb.push_back('{qexp, ap, bp, t0 + 1, t0 + N + 2});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int t0;
      total = 0; bad = 0;
      reset = 1'b1; force_q = 1'b0;
      bus.start = 1'b0; bus.a_pat = '0; bus.b_pat = '0;
      busy_n = 0; prime_n = 0; prime_at = -1; run_k = 0; a_tr = '0; b_tr = '0;
      repeat (3) @(negedge clk);
      chk("rst_q_word", bus.q_word, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pins", {bus.a, bus.b, bus.dut_rst}, 3'b000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      kick(8'h0F, 8'h00, 8'h0E); wait_idle();
      chk("q_word_hold", bus.q_word, 8'h0E);
      kick(8'h01, 8'hFF, 8'h03); wait_idle();
      kick(8'hAA, 8'h00, 8'h00); wait_idle();
      kick(8'hAA, 8'hFF, 8'hFE); wait_idle();

      // start pulse and pattern change during RUN must be ignored
      kick(8'h0F, 8'h00, 8'h0E);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.a_pat = 8'hFF; bus.b_pat = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);
      chk("no_second_run", sb.size(), 0);

      // start held high: back-to-back runs, second PRIME right after IDLE
      @(negedge clk);
      bus.a_pat = 8'h01; bus.b_pat = 8'hFF; bus.start = 1'b1;
      t0 = cyc;
      sb.push_back('{8'h03, 8'h01, 8'hFF, t0 + 1, t0 + N + 2});
      sb.push_back('{8'h03, 8'h01, 8'hFF, t0 + N + 4, t0 + 2 * N + 5});
      repeat (N + 5) @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // reset while RUN is at index 3
      @(negedge clk);
      bus.a_pat = 8'h0F; bus.b_pat = 8'h00; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_abort_q_word", bus.q_word, 8'h06);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_q_word", bus.q_word, 0);
      chk("abort_pins", {bus.a, bus.b, bus.dut_rst}, 3'b000);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_done", sb.size(), 0);

`ifdef DRIVER_SELF_CHECK_EN
      force_q = 1'b1;
      kick(8'h0F, 8'h00, 8'h00); wait_idle();
      chk("mismatch_set", bus.mismatch, 1);
      chk("err_idx", bus.err_idx, 1);
      force_q = 1'b0;
      kick(8'h0F, 8'h00, 8'h0E); wait_idle();
      chk("mismatch_clear", bus.mismatch, 0);
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
